// File: rtl/zorro_pkg.sv
// Shared types and constants for the Zorro III bus-master cycle engine.
//   state_t    : master-cycle sequencer states
//   DS_IDLE    : negated data-strobe pattern
//   SYNC_DEPTH : flop count for the DTACK_n / BERR_n synchronizers
package zorro_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        STROBE,
        WAIT_ACK,
        DONE,
        ERROR,
        RECOVER
    } state_t;

    localparam logic [3:0]  DS_IDLE    = 4'hF;
    localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/zorro_sync2.sv
// Flop-chain synchronizer for an asynchronous active-low bus input.
// Resets to 1 so that the synchronized strobe reads as negated.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous input
//   q_o    : synchronized output
module zorro_sync2
    import zorro_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_DEPTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/zorro_master_cycle.sv
// Zorro III bus-master cycle sequencer. Runs one 32-bit master cycle per
// local request while the arbiter grants the bus (MYBUS_n low), and keeps
// FCS asserted so the arbiter holds the bus until the cycle has finished.
//   CLK, RESET_n            : clock, asynchronous active-low reset
//   MYBUS_n                 : bus grant from arbiter (active low)
//   L_REQ/L_WRITE/L_BE/
//   L_ADDR/L_WDATA          : local request and its attributes
//   L_RDATA/L_ACK/L_ERR     : read data, completion and error pulses
//   FCS/DS_n/READ/DOE       : Zorro III cycle strobes
//   AD_OE/AD_OUT/AD_IN      : multiplexed address/data bus
//   DTACK_n/BERR_n          : asynchronous bus termination inputs
//   BUSY                    : sequencer not idle
module zorro_master_cycle
    import zorro_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned ADDR_SETUP     = 1
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        MYBUS_n,
    input  logic        L_REQ,
    input  logic        L_WRITE,
    input  logic [3:0]  L_BE,
    input  logic [31:0] L_ADDR,
    input  logic [31:0] L_WDATA,
    output logic [31:0] L_RDATA,
    output logic        L_ACK,
    output logic        L_ERR,
    output logic        FCS,
    output logic [3:0]  DS_n,
    output logic        READ,
    output logic        DOE,
    output logic        AD_OE,
    output logic [31:0] AD_OUT,
    input  logic [31:0] AD_IN,
    input  logic        DTACK_n,
    input  logic        BERR_n,
    output logic        BUSY
);

    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] SETUP_LAST = 2'(ADDR_SETUP - 1);

    logic dtack_n_s;
    logic berr_n_s;

    zorro_sync2 u_sync_dtack (
        .clk_i  (CLK),
        .rst_ni (RESET_n),
        .d_i    (DTACK_n),
        .q_o    (dtack_n_s)
    );

    zorro_sync2 u_sync_berr (
        .clk_i  (CLK),
        .rst_ni (RESET_n),
        .d_i    (BERR_n),
        .q_o    (berr_n_s)
    );

    state_t      state_q;
    logic        wr_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  setup_cnt_q;
    logic [7:0]  to_cnt_q;

    logic        fcs_q;
    logic [3:0]  ds_n_q;
    logic        read_q;
    logic        doe_q;
    logic        ad_oe_q;
    logic [31:0] ad_out_q;
    logic [31:0] rdata_q;
    logic        ack_q;
    logic        err_q;
    logic        busy_q;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            setup_cnt_q <= '0;
            to_cnt_q    <= '0;
            fcs_q       <= 1'b0;
            ds_n_q      <= DS_IDLE;
            read_q      <= 1'b1;
            doe_q       <= 1'b0;
            ad_oe_q     <= 1'b0;
            ad_out_q    <= '0;
            rdata_q     <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses.
            ack_q <= 1'b0;
            err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (L_REQ && !MYBUS_n) begin
                        wr_q        <= L_WRITE;
                        be_q        <= L_BE;
                        addr_q      <= L_ADDR;
                        wdata_q     <= L_WDATA;
                        setup_cnt_q <= '0;
                        ad_oe_q     <= 1'b1;
                        ad_out_q    <= L_ADDR;
                        read_q      <= ~L_WRITE;
                        busy_q      <= 1'b1;
                        state_q     <= ADDR;
                    end
                end

                ADDR: begin
                    // Grant lost before FCS: back off, request stays pending.
                    if (MYBUS_n) begin
                        ad_oe_q  <= 1'b0;
                        ad_out_q <= '0;
                        read_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else if (setup_cnt_q == SETUP_LAST) begin
                        fcs_q   <= 1'b1;
                        ad_oe_q <= wr_q;
                        if (wr_q) begin
                            ad_out_q <= wdata_q;
                        end
                        state_q <= STROBE;
                    end else begin
                        setup_cnt_q <= setup_cnt_q + 2'd1;
                    end
                end

                STROBE: begin
                    ds_n_q   <= ~be_q;
                    doe_q    <= 1'b1;
                    to_cnt_q <= '0;
                    state_q  <= WAIT_ACK;
                end

                WAIT_ACK: begin
                    // BERR has priority over DTACK; DTACK over timeout.
                    if (!berr_n_s || (dtack_n_s && (to_cnt_q == TO_LAST))) begin
                        fcs_q   <= 1'b0;
                        ds_n_q  <= DS_IDLE;
                        doe_q   <= 1'b0;
                        ad_oe_q <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ERROR;
                    end else if (!dtack_n_s) begin
                        fcs_q   <= 1'b0;
                        ds_n_q  <= DS_IDLE;
                        doe_q   <= 1'b0;
                        ad_oe_q <= 1'b0;
                        ack_q   <= 1'b1;
                        if (!wr_q) begin
                            rdata_q <= AD_IN;
                        end
                        state_q <= DONE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 8'd1;
                    end
                end

                DONE, ERROR: begin
                    state_q <= RECOVER;
                end

                RECOVER: begin
                    if (dtack_n_s && berr_n_s) begin
                        read_q   <= 1'b1;
                        ad_out_q <= '0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign L_RDATA = rdata_q;
    assign L_ACK   = ack_q;
    assign L_ERR   = err_q;
    assign FCS     = fcs_q;
    assign DS_n    = ds_n_q;
    assign READ    = read_q;
    assign DOE     = doe_q;
    assign AD_OE   = ad_oe_q;
    assign AD_OUT  = ad_out_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_zorro_master_cycle.sv
// Directed bench for zorro_master_cycle: a table of complete bus cycles
// plus hand-written timeout, bus-grant and mid-cycle reset sequences.
module tb_zorro_master_cycle;

    logic        CLK = 1'b0;
    logic        RESET_n;
    logic        MYBUS_n;
    logic        L_REQ;
    logic        L_WRITE;
    logic [3:0]  L_BE;
    logic [31:0] L_ADDR;
    logic [31:0] L_WDATA;
    logic [31:0] L_RDATA;
    logic        L_ACK;
    logic        L_ERR;
    logic        FCS;
    logic [3:0]  DS_n;
    logic        READ;
    logic        DOE;
    logic        AD_OE;
    logic [31:0] AD_OUT;
    logic [31:0] AD_IN;
    logic        DTACK_n;
    logic        BERR_n;
    logic        BUSY;

    zorro_master_cycle #(
        .TIMEOUT_CYCLES (8),
        .ADDR_SETUP     (1)
    ) dut (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .MYBUS_n (MYBUS_n),
        .L_REQ   (L_REQ),
        .L_WRITE (L_WRITE),
        .L_BE    (L_BE),
        .L_ADDR  (L_ADDR),
        .L_WDATA (L_WDATA),
        .L_RDATA (L_RDATA),
        .L_ACK   (L_ACK),
        .L_ERR   (L_ERR),
        .FCS     (FCS),
        .DS_n    (DS_n),
        .READ    (READ),
        .DOE     (DOE),
        .AD_OE   (AD_OE),
        .AD_OUT  (AD_OUT),
        .AD_IN   (AD_IN),
        .DTACK_n (DTACK_n),
        .BERR_n  (BERR_n),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ad_in;
        int unsigned dly;       // ticks after DS_n asserts before DTACK_n drops
        logic        berr;      // drop BERR_n together with DTACK_n
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_ds_n;
        logic        exp_read;
    } vec_t;

    vec_t vecs[4];

    int n_cmp = 0;
    int n_fail = 0;
    int ack_seen = 0;
    int err_seen = 0;
    int both_seen = 0;

    // Pulse counters sampled on the opposite edge.
    always @(negedge CLK) begin
        if (L_ACK === 1'b1) ack_seen++;
        if (L_ERR === 1'b1) err_seen++;
        if (L_ACK === 1'b1 && L_ERR === 1'b1) both_seen++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Tick until L_ACK or L_ERR, bounded; returns tick count and hit flag.
    task automatic wait_term(output int n, output logic hit);
        n = 0;
        hit = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            n++;
            if (L_ACK === 1'b1 || L_ERR === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    // Tick until BUSY drops, bounded.
    task automatic wait_idle(output int n, output logic hit);
        n = 0;
        hit = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            n++;
            if (BUSY === 1'b0) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int a0, e0, n;
        logic hit;
        v  = vecs[i];
        a0 = ack_seen;
        e0 = err_seen;
        L_WRITE = v.wr;
        L_BE    = v.be;
        L_ADDR  = v.addr;
        L_WDATA = v.wdata;
        AD_IN   = v.ad_in;
        L_REQ   = 1'b1;

        tick();  // ADDR
        chk($sformatf("v%0d addr AD_OE", i), AD_OE, 1);
        chk($sformatf("v%0d addr AD_OUT", i), AD_OUT, v.addr);
        chk($sformatf("v%0d addr FCS", i), FCS, 0);
        chk($sformatf("v%0d addr READ", i), READ, v.exp_read);
        chk($sformatf("v%0d addr BUSY", i), BUSY, 1);

        tick();  // STROBE
        chk($sformatf("v%0d strobe FCS", i), FCS, 1);
        chk($sformatf("v%0d strobe DS_n", i), DS_n, 4'hF);
        chk($sformatf("v%0d strobe AD_OE", i), AD_OE, v.wr);
        if (v.wr) chk($sformatf("v%0d strobe AD_OUT", i), AD_OUT, v.wdata);

        tick();  // WAIT_ACK
        chk($sformatf("v%0d wait DS_n", i), DS_n, v.exp_ds_n);
        chk($sformatf("v%0d wait DOE", i), DOE, 1);
        chk($sformatf("v%0d wait FCS", i), FCS, 1);
        if (v.wr) begin
            chk($sformatf("v%0d wait AD_OE", i), AD_OE, 1);
            chk($sformatf("v%0d wait AD_OUT", i), AD_OUT, v.wdata);
        end

        repeat (v.dly) tick();
        DTACK_n = 1'b0;
        if (v.berr) BERR_n = 1'b0;

        wait_term(n, hit);
        chk($sformatf("v%0d terminated", i), hit, 1);
        chk($sformatf("v%0d term latency", i), n, 3);
        chk($sformatf("v%0d L_ACK", i), L_ACK, v.exp_ack);
        chk($sformatf("v%0d L_ERR", i), L_ERR, v.exp_err);
        chk($sformatf("v%0d L_RDATA", i), L_RDATA, v.exp_rdata);
        chk($sformatf("v%0d rel FCS", i), FCS, 0);
        chk($sformatf("v%0d rel DS_n", i), DS_n, 4'hF);
        chk($sformatf("v%0d rel DOE", i), DOE, 0);
        chk($sformatf("v%0d rel AD_OE", i), AD_OE, 0);
        L_REQ = 1'b0;

        tick();  // RECOVER, termination still held low
        chk($sformatf("v%0d pulse L_ACK", i), L_ACK, 0);
        chk($sformatf("v%0d pulse L_ERR", i), L_ERR, 0);
        chk($sformatf("v%0d recover BUSY", i), BUSY, 1);
        DTACK_n = 1'b1;
        BERR_n  = 1'b1;

        wait_idle(n, hit);
        chk($sformatf("v%0d idle reached", i), hit, 1);
        chk($sformatf("v%0d idle latency", i), n, 3);
        tick();
        chk($sformatf("v%0d ack count", i), ack_seen - a0, v.exp_ack);
        chk($sformatf("v%0d err count", i), err_seen - e0, v.exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a0, e0;
        logic hit;

        //             wr    be     addr          wdata         ad_in         dly berr ack   err   rdata         ds_n   read
        vecs[0] = '{1'b0, 4'hF, 32'h40001000, 32'h00000000, 32'hDEADBEEF, 3, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 4'h0, 1'b1};
        vecs[1] = '{1'b1, 4'h3, 32'h40001004, 32'h12345678, 32'h00000000, 2, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 4'hC, 1'b0};
        vecs[2] = '{1'b0, 4'hF, 32'h40001008, 32'h00000000, 32'hCAFEF00D, 1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 4'h0, 1'b1};
        vecs[3] = '{1'b0, 4'h8, 32'h40002004, 32'h00000000, 32'h0BADF00D, 0, 1'b0, 1'b1, 1'b0, 32'h0BADF00D, 4'h7, 1'b1};

        RESET_n = 1'b0;
        MYBUS_n = 1'b0;
        L_REQ   = 1'b0;
        L_WRITE = 1'b0;
        L_BE    = 4'h0;
        L_ADDR  = '0;
        L_WDATA = '0;
        AD_IN   = '0;
        DTACK_n = 1'b1;
        BERR_n  = 1'b1;
        tick();
        tick();
        chk("reset FCS", FCS, 0);
        chk("reset DS_n", DS_n, 4'hF);
        chk("reset READ", READ, 1);
        chk("reset DOE", DOE, 0);
        chk("reset AD_OE", AD_OE, 0);
        chk("reset AD_OUT", AD_OUT, 0);
        chk("reset L_RDATA", L_RDATA, 0);
        chk("reset L_ACK", L_ACK, 0);
        chk("reset L_ERR", L_ERR, 0);
        chk("reset BUSY", BUSY, 0);
        RESET_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run_vec(i);

        // Timeout: DTACK_n never asserts, TIMEOUT_CYCLES = 8.
        a0 = ack_seen;
        e0 = err_seen;
        L_WRITE = 1'b0;
        L_BE    = 4'hF;
        L_ADDR  = 32'h40003000;
        L_REQ   = 1'b1;
        repeat (3) tick();
        chk("to wait DOE", DOE, 1);
        wait_term(n, hit);
        chk("to terminated", hit, 1);
        chk("to latency", n, 8);
        chk("to L_ERR", L_ERR, 1);
        chk("to L_ACK", L_ACK, 0);
        chk("to rel FCS", FCS, 0);
        chk("to rel DS_n", DS_n, 4'hF);
        chk("to rel DOE", DOE, 0);
        chk("to L_RDATA kept", L_RDATA, 32'h0BADF00D);
        L_REQ = 1'b0;
        wait_idle(n, hit);
        chk("to idle reached", hit, 1);
        tick();
        chk("to ack count", ack_seen - a0, 0);
        chk("to err count", err_seen - e0, 1);

        // Bus not granted: request waits; grant lost in ADDR aborts.
        a0 = ack_seen;
        e0 = err_seen;
        MYBUS_n = 1'b1;
        L_WRITE = 1'b0;
        L_BE    = 4'hF;
        L_ADDR  = 32'h40004000;
        AD_IN   = 32'h600DCAFE;
        L_REQ   = 1'b1;
        repeat (4) tick();
        chk("nobus BUSY", BUSY, 0);
        chk("nobus AD_OE", AD_OE, 0);
        MYBUS_n = 1'b0;
        tick();
        chk("grant BUSY", BUSY, 1);
        chk("grant AD_OE", AD_OE, 1);
        MYBUS_n = 1'b1;
        tick();
        chk("abort BUSY", BUSY, 0);
        chk("abort FCS", FCS, 0);
        chk("abort AD_OE", AD_OE, 0);
        tick();
        chk("abort stays idle", BUSY, 0);
        chk("abort no FCS", FCS, 0);
        MYBUS_n = 1'b0;
        tick();  // ADDR
        tick();  // STROBE
        chk("regrant FCS", FCS, 1);
        MYBUS_n = 1'b1;  // ignored once FCS is asserted
        tick();  // WAIT_ACK
        chk("regrant DS_n", DS_n, 4'h0);
        chk("regrant FCS held", FCS, 1);
        DTACK_n = 1'b0;
        wait_term(n, hit);
        chk("regrant terminated", hit, 1);
        chk("regrant L_ACK", L_ACK, 1);
        chk("regrant L_RDATA", L_RDATA, 32'h600DCAFE);
        L_REQ   = 1'b0;
        DTACK_n = 1'b1;
        wait_idle(n, hit);
        chk("regrant idle reached", hit, 1);
        MYBUS_n = 1'b0;
        tick();
        chk("bus ack count", ack_seen - a0, 1);
        chk("bus err count", err_seen - e0, 0);

        // Asynchronous reset during WAIT_ACK.
        L_WRITE = 1'b1;
        L_BE    = 4'hF;
        L_ADDR  = 32'h40005000;
        L_WDATA = 32'hA5A5A5A5;
        L_REQ   = 1'b1;
        repeat (3) tick();
        tick();
        chk("prerst DOE", DOE, 1);
        #2;
        RESET_n = 1'b0;
        #1;
        chk("arst FCS", FCS, 0);
        chk("arst DS_n", DS_n, 4'hF);
        chk("arst READ", READ, 1);
        chk("arst DOE", DOE, 0);
        chk("arst AD_OE", AD_OE, 0);
        chk("arst AD_OUT", AD_OUT, 0);
        chk("arst L_RDATA", L_RDATA, 0);
        chk("arst BUSY", BUSY, 0);
        L_REQ = 1'b0;
        tick();
        RESET_n = 1'b1;
        tick();
        run_vec(0);

        chk("never ACK and ERR together", both_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
